mem_port_arbiter: RTL and testbench

- Shares the single-port instruction/data memory (8-bit address, 16-bit word, combinational read, level-sensitive write enable) between two requesters.
  - Instruction-fetch port (IF): read-only.
  - Data port (DM): load/store.
- Sits between the pipelined core front end/LSU and the memory block.
- Owns all memory address, write-data and write-enable drive, so the core never drives memory directly.
- Arbitration: fixed data priority with a fetch-starvation bound; fetch responses are flushable on redirect.

---
 rtl/mem_port_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
`timescale 1ns/1ps
// Bundle between the core-side requesters (fetch + data) and the shared
// single-port memory; the arbiter sits on the slave side.
interface mem_port_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_flush;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;

  logic          dm_req_valid;
  logic          dm_req_ready;
  logic          dm_req_we;
  logic [AW-1:0] dm_req_addr;
  logic [DW-1:0] dm_req_wdata;
  logic          dm_rsp_valid;
  logic [DW-1:0] dm_rsp_data;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one single-port memory between fetch and data requesters: data wins
// contention until fetch has lost MAX_STARVE times in a row.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int MAX_STARVE = 3
) (
  input  logic      clk,
  input  logic      reset_n,
  mem_port_if.slave bus,
  output logic      busy
);
  localparam int              SW         = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [1:0]      IDLE       = 2'd0;
  localparam logic [1:0]      ACCESS     = 2'd1;
  localparam logic [1:0]      RESP       = 2'd2;

  typedef struct packed {
    logic          is_if;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  req_t          req_q, req_d;
  logic          if_keep_q, if_keep_d;
  logic [DW-1:0] if_data_q, if_data_d;
  logic [DW-1:0] dm_data_q, dm_data_d;

  logic open_win, if_elig, dm_rdy, if_rdy, if_gnt, dm_gnt;

  // Grant window is IDLE or RESP; a flushing fetch is never eligible.
  assign open_win = (state_q == IDLE) || (state_q == RESP);
  assign if_elig  = bus.if_req_valid && !bus.if_flush;
  assign dm_rdy   = open_win && bus.dm_req_valid && (!if_elig || (starve_q != STARVE_MAX));
  assign if_rdy   = open_win && if_elig && !dm_rdy;
  assign if_gnt   = bus.if_req_valid && if_rdy;
  assign dm_gnt   = bus.dm_req_valid && dm_rdy;

  assign bus.dm_req_ready = dm_rdy;
  assign bus.if_req_ready = if_rdy;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    if_keep_d = if_keep_q;
    if_data_d = if_data_q;
    dm_data_d = dm_data_q;
    case (state_q)
      ACCESS: begin
        state_d = RESP;
        if (req_q.is_if) begin
          // A flush seen during the access drops this fetch's response.
          if_keep_d = !bus.if_flush;
          if (!bus.if_flush) if_data_d = bus.mem_rdata;
        end else begin
          dm_data_d = req_q.we ? '0 : bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    if (if_gnt || dm_gnt) begin
      state_d     = ACCESS;
      req_d.is_if = if_gnt;
      req_d.we    = dm_gnt && bus.dm_req_we;
      req_d.addr  = if_gnt ? bus.if_req_addr : bus.dm_req_addr;
      // Fetches leave the write-data bus untouched.
      req_d.wdata = dm_gnt ? bus.dm_req_wdata : req_q.wdata;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req_valid || if_gnt)
      starve_d = '0;
    else if (dm_gnt && (starve_q != STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      req_q     <= '0;
      if_keep_q <= 1'b0;
      if_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      req_q     <= req_d;
      if_keep_q <= if_keep_d;
      if_data_q <= if_data_d;
      dm_data_q <= dm_data_d;
    end
  end

  // Memory drive comes straight from the latched request, so it only moves on accept.
  assign bus.mem_addr     = req_q.addr;
  assign bus.mem_wdata    = req_q.wdata;
  assign bus.mem_we       = (state_q == ACCESS) && req_q.we;

  assign bus.if_rsp_valid = (state_q == RESP) && req_q.is_if && if_keep_q && !bus.if_flush;
  assign bus.dm_rsp_valid = (state_q == RESP) && !req_q.is_if;
  assign bus.if_rsp_data  = if_data_q;
  assign bus.dm_rsp_data  = dm_data_q;

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MS = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  mem_port_if #(.AW(AW), .DW(DW)) bus();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STARVE(MS)) dut (
    .clk    (clk),
    .reset_n(rst_n),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 'h30) return 16'h000B;
    if (i == 'h32) return 16'h0002;
    if (i == 'h33) return 16'h0003;
    return 16'(i * 7 + 256);
  endfunction

  // Memory behind the arbiter
  logic [DW-1:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Transaction-level model: age = edges since the last accepted request.
  int            age, starve;
  logic          c_if, c_we, drop;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wd, e_ifd, e_dmd, rd;
  logic          elig, e_dmr, e_ifr, e_ifv, e_dmv;
  logic [DW-1:0] mdl_mem [256];

  task automatic mdl_reset();
    age = 3; starve = 0; c_if = 1'b0; c_we = 1'b0; drop = 1'b0;
    c_addr = '0; c_wd = '0; e_ifd = '0; e_dmd = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);
    mdl_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdl_reset();
      end else begin
        elig  = bus.if_req_valid && !bus.if_flush;
        e_dmr = (age != 1) && bus.dm_req_valid && (!elig || starve != MS);
        e_ifr = (age != 1) && elig && !e_dmr;
        e_ifv = (age == 2) && c_if && !drop && !bus.if_flush;
        e_dmv = (age == 2) && !c_if;
        chk("if_req_ready", 32'(bus.if_req_ready), 32'(e_ifr));
        chk("dm_req_ready", 32'(bus.dm_req_ready), 32'(e_dmr));
        chk("busy",         32'(busy),             32'(age == 1 || age == 2));
        chk("mem_we",       32'(bus.mem_we),       32'(age == 1 && c_we));
        chk("mem_addr",     32'(bus.mem_addr),     32'(c_addr));
        chk("mem_wdata",    32'(bus.mem_wdata),    32'(c_wd));
        chk("if_rsp_valid", 32'(bus.if_rsp_valid), 32'(e_ifv));
        chk("dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'(e_dmv));
        chk("if_rsp_data",  32'(bus.if_rsp_data),  32'(e_ifd));
        chk("dm_rsp_data",  32'(bus.dm_rsp_data),  32'(e_dmd));
        if (age == 1) begin
          rd = mdl_mem[c_addr];
          if (c_we) mdl_mem[c_addr] = c_wd;
          if (c_if) begin
            drop = bus.if_flush;
            if (!bus.if_flush) e_ifd = rd;
          end else begin
            e_dmd = c_we ? '0 : rd;
          end
        end
        if (bus.if_req_valid && e_ifr) begin
          c_if = 1'b1; c_we = 1'b0; c_addr = bus.if_req_addr;
          age = 1; starve = 0;
        end else if (bus.dm_req_valid && e_dmr) begin
          c_if = 1'b0; c_we = bus.dm_req_we; c_addr = bus.dm_req_addr;
          c_wd = bus.dm_req_wdata; age = 1;
          if (!bus.if_req_valid) starve = 0;
          else if (starve < MS) starve++;
        end else begin
          if (age < 3) age++;
          if (!bus.if_req_valid) starve = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    bus.if_req_valid = 1'b0; bus.if_req_addr = '0; bus.if_flush = 1'b0;
    bus.dm_req_valid = 1'b0; bus.dm_req_we = 1'b0;
    bus.dm_req_addr = '0; bus.dm_req_wdata = '0;
  endtask

  int            n, seen;
  logic [7:0]    pat;

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);

    // Single fetch of 0x30
    cyc(); bus.if_req_valid = 1'b1; bus.if_req_addr = 8'h30;
    @(negedge clk); chk("t1_ready", 32'(bus.if_req_ready), 32'd1);
    cyc(); clr();
    @(negedge clk); chk("t1_acc_busy", 32'(busy), 32'd1);
    chk("t1_acc_addr", 32'(bus.mem_addr), 32'h30);
    @(negedge clk); chk("t1_rsp_v", 32'(bus.if_rsp_valid), 32'd1);
    chk("t1_rsp_d", 32'(bus.if_rsp_data), 32'h000B);
    chk("t1_rsp_busy", 32'(busy), 32'd1);
    @(negedge clk); chk("t1_idle", 32'(busy), 32'd0);

    // Store 0x1234 to 0x31 then load it back
    cyc(); bus.dm_req_valid = 1'b1; bus.dm_req_we = 1'b1;
    bus.dm_req_addr = 8'h31; bus.dm_req_wdata = 16'h1234;
    cyc(); bus.dm_req_we = 1'b0; bus.dm_req_wdata = 16'hFFFF;
    @(negedge clk); chk("t2_we", 32'(bus.mem_we), 32'd1);
    chk("t2_wd", 32'(bus.mem_wdata), 32'h1234);
    cyc();
    @(negedge clk); chk("t2_ack", 32'(bus.dm_rsp_valid), 32'd1);
    chk("t2_ackd", 32'(bus.dm_rsp_data), 32'd0);
    cyc(); clr();
    @(negedge clk); chk("t2_ld_we", 32'(bus.mem_we), 32'd0);
    cyc();
    @(negedge clk); chk("t2_ld_v", 32'(bus.dm_rsp_valid), 32'd1);
    chk("t2_ld_d", 32'(bus.dm_rsp_data), 32'h1234);

    // Back-to-back loads 0x32, 0x33, second accepted in RESP
    cyc(); bus.dm_req_valid = 1'b1; bus.dm_req_addr = 8'h32;
    cyc(); bus.dm_req_addr = 8'h33;
    @(negedge clk); chk("t5_acc_rdy", 32'(bus.dm_req_ready), 32'd0);
    cyc();
    @(negedge clk); chk("t5_r1_v", 32'(bus.dm_rsp_valid), 32'd1);
    chk("t5_r1_d", 32'(bus.dm_rsp_data), 32'h0002);
    chk("t5_resp_rdy", 32'(bus.dm_req_ready), 32'd1);
    cyc(); clr();
    cyc();
    @(negedge clk); chk("t5_r2_v", 32'(bus.dm_rsp_valid), 32'd1);
    chk("t5_r2_d", 32'(bus.dm_rsp_data), 32'h0003);

    // Flush during ACCESS of a fetch, DM load 0x33 alongside
    seen = 0;
    cyc(); bus.if_req_valid = 1'b1; bus.if_req_addr = 8'h40;
    cyc(); bus.if_req_valid = 1'b0; bus.if_flush = 1'b1;
    bus.dm_req_valid = 1'b1; bus.dm_req_addr = 8'h33;
    @(negedge clk); seen += int'(bus.if_rsp_valid);
    cyc(); bus.if_flush = 1'b0;
    @(negedge clk); seen += int'(bus.if_rsp_valid);
    chk("fl1_dm_rdy", 32'(bus.dm_req_ready), 32'd1);
    cyc(); clr();
    @(negedge clk); seen += int'(bus.if_rsp_valid);
    cyc();
    @(negedge clk); seen += int'(bus.if_rsp_valid);
    chk("fl1_dm_v", 32'(bus.dm_rsp_valid), 32'd1);
    chk("fl1_dm_d", 32'(bus.dm_rsp_data), 32'h0003);
    chk("fl1_no_if", 32'(seen), 32'd0);

    // Flush during RESP of a fetch, DM load 0x32 alongside
    seen = 0;
    cyc(); bus.if_req_valid = 1'b1; bus.if_req_addr = 8'h41;
    cyc(); bus.if_req_valid = 1'b0; bus.dm_req_valid = 1'b1; bus.dm_req_addr = 8'h32;
    @(negedge clk); seen += int'(bus.if_rsp_valid);
    cyc(); bus.if_flush = 1'b1;
    @(negedge clk); seen += int'(bus.if_rsp_valid);
    chk("fl2_dm_rdy", 32'(bus.dm_req_ready), 32'd1);
    cyc(); clr();
    @(negedge clk); seen += int'(bus.if_rsp_valid);
    cyc();
    @(negedge clk); chk("fl2_dm_v", 32'(bus.dm_rsp_valid), 32'd1);
    chk("fl2_dm_d", 32'(bus.dm_rsp_data), 32'h0002);
    chk("fl2_no_if", 32'(seen), 32'd0);

    // Both requesters continuously valid: expect DM,DM,DM,IF repeating
    cyc(); cyc();
    bus.if_req_valid = 1'b1; bus.dm_req_valid = 1'b1;
    n = 0; pat = '0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      bus.if_req_addr  = 8'($urandom_range(128, 255));
      bus.dm_req_addr  = 8'($urandom_range(128, 255));
      bus.dm_req_we    = 1'($urandom_range(0, 1));
      bus.dm_req_wdata = 16'($urandom);
      @(negedge clk);
      if (bus.dm_rsp_valid) begin pat = {pat[6:0], 1'b0}; n++; end
      if (bus.if_rsp_valid) begin pat = {pat[6:0], 1'b1}; n++; end
      cyc();
    end
    clr();
    chk("starve_nrsp", 32'(n), 32'd8);
    chk("starve_pattern", 32'(pat), 32'h11);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      cyc();
      bus.if_req_valid = ($urandom_range(0, 99) < 50);
      bus.dm_req_valid = ($urandom_range(0, 99) < 50);
      bus.if_req_addr  = 8'($urandom_range(128, 255));
      bus.dm_req_addr  = 8'($urandom_range(128, 255));
      bus.dm_req_we    = 1'($urandom_range(0, 1));
      bus.dm_req_wdata = 16'($urandom);
      bus.if_flush     = ($urandom_range(0, 9) == 0);
    end
    cyc(); clr();
    repeat (3) cyc();

    // Reset dropped mid-ACCESS of a store
    bus.dm_req_valid = 1'b1; bus.dm_req_we = 1'b1;
    bus.dm_req_addr = 8'hEE; bus.dm_req_wdata = 16'hBEEF;
    cyc(); clr();
    chk("rst_pre_we", 32'(bus.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_state", 32'(busy), 32'd0);
    chk("rst_dm_v", 32'(bus.dm_rsp_valid), 32'd0);
    chk("rst_if_v", 32'(bus.if_rsp_valid), 32'd0);
    cyc(); cyc();
    #2 rst_n = 1'b1;
    cyc(); bus.if_req_valid = 1'b1; bus.if_req_addr = 8'h30;
    @(negedge clk); chk("post_rdy", 32'(bus.if_req_ready), 32'd1);
    cyc(); clr();
    cyc();
    @(negedge clk); chk("post_v", 32'(bus.if_rsp_valid), 32'd1);
    chk("post_d", 32'(bus.if_rsp_data), 32'h000B);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
